ct_rtu_preg_alloc_64: RTL and testbench

//  Physical-register free-list allocator for the retire unit. Keeps a 64-entry free bitmap.
//  Pre-selects the next free entry round-robin into a one-hot staging register.

---
 rtl/ct_rtu_preg_alloc_64_pkg.sv | 11 +
 rtl/ct_rtu_enc_64.sv | 9 +
 rtl/ct_rtu_rr_pick_64.sv | 16 +
 rtl/ct_rtu_preg_alloc_64.sv | 67 ++++++
 tb/tb_ct_rtu_preg_alloc_64.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ct_rtu_preg_alloc_64_pkg.sv
// ct_rtu_preg_alloc_64_pkg: shared sizing constants and one-hot index helper
package ct_rtu_preg_alloc_64_pkg;
  localparam int ENTRY_NUM = 64;
  localparam int PTR_W = 6;
  localparam int CNT_W = PTR_W + 1;
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [ENTRY_NUM-1:0] oh);
    onehot_to_idx = '0;
    for (int i = 0; i < ENTRY_NUM; i++)
      onehot_to_idx = onehot_to_idx | (oh[i] ? PTR_W'(i) : '0);
  endfunction
endpackage

// File: rtl/ct_rtu_enc_64.sv
// ct_rtu_enc_64: 64->6 one-hot to index encoder
module ct_rtu_enc_64
  import ct_rtu_preg_alloc_64_pkg::*;
(
  input  logic [ENTRY_NUM-1:0] onehot,
  output logic [PTR_W-1:0]     idx
);
  assign idx = onehot_to_idx(onehot);
endmodule

// File: rtl/ct_rtu_rr_pick_64.sv
// ct_rtu_rr_pick_64: lowest set bit at or above ptr, wrapping to the lowest set bit overall
module ct_rtu_rr_pick_64
  import ct_rtu_preg_alloc_64_pkg::*;
(
  input  logic [ENTRY_NUM-1:0] vec,
  input  logic [PTR_W-1:0]     ptr,
  output logic [ENTRY_NUM-1:0] pick,
  output logic                 found
);
  logic [ENTRY_NUM-1:0] mask;
  logic [ENTRY_NUM-1:0] sel;
  assign mask  = vec & ~((ENTRY_NUM'(1) << ptr) - ENTRY_NUM'(1));
  assign sel   = |mask ? mask : vec;
  assign pick  = sel & (~sel + ENTRY_NUM'(1));
  assign found = |vec;
endmodule

// File: rtl/ct_rtu_preg_alloc_64.sv
// ct_rtu_preg_alloc_64: round-robin physical register free-list allocator with one-hot staging
module ct_rtu_preg_alloc_64
  import ct_rtu_preg_alloc_64_pkg::*;
(
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 rtu_alloc_req,
  output logic                 rtu_alloc_gnt,
  output logic [ENTRY_NUM-1:0] rtu_alloc_preg_expand,
  output logic                 rtu_alloc_vld,
  input  logic                 rtu_release_vld,
  input  logic [ENTRY_NUM-1:0] rtu_release_expand,
  input  logic                 rtu_flush,
  input  logic [ENTRY_NUM-1:0] rtu_flush_free_expand,
  output logic [CNT_W-1:0]     rtu_free_cnt,
  output logic                 rtu_alloc_empty
);
  logic [ENTRY_NUM-1:0] free_q;
  logic [ENTRY_NUM-1:0] stage_q;
  logic                 stage_vld_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [ENTRY_NUM-1:0] pick;
  logic                 found;
  logic [PTR_W-1:0]     pick_idx;
  logic                 refill;

  ct_rtu_rr_pick_64 u_pick (.vec(free_q), .ptr(ptr_q), .pick(pick), .found(found));
  ct_rtu_enc_64 u_enc (.onehot(pick), .idx(pick_idx));

  assign rtu_alloc_gnt         = rtu_alloc_req & stage_vld_q & ~rtu_flush;
  assign refill                = ~stage_vld_q | rtu_alloc_gnt;
  assign rtu_alloc_preg_expand = stage_q;
  assign rtu_alloc_vld         = stage_vld_q;
  assign rtu_alloc_empty       = rtu_free_cnt == '0;

  // The staged entry is reserved outside free_q but still counts as free.
  always_comb begin
    rtu_free_cnt = {{PTR_W{1'b0}}, stage_vld_q};
    for (int i = 0; i < ENTRY_NUM; i++)
      rtu_free_cnt = rtu_free_cnt + {{PTR_W{1'b0}}, free_q[i]};
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      free_q      <= '1;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      ptr_q       <= '0;
    end else if (rtu_flush) begin
      free_q      <= rtu_flush_free_expand;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
    end else begin
      free_q <= (free_q & ~(refill ? pick : '0)) | (rtu_release_vld ? rtu_release_expand : '0);
      if (refill) begin
        stage_q     <= pick;
        stage_vld_q <= found;
        ptr_q       <= found ? pick_idx + PTR_W'(1) : ptr_q;
      end
    end
  end

  a_no_overlap: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    (free_q & stage_q) == '0);
  a_legal_release: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    (rtu_release_vld && !rtu_flush) |-> ((rtu_release_expand & (free_q | stage_q)) == '0));
endmodule

// File: tb/tb_ct_rtu_preg_alloc_64.sv
// tb_ct_rtu_preg_alloc_64: randomized and directed checks against a behavioural free-list model
module tb_ct_rtu_preg_alloc_64;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        gnt;
  logic [63:0] expand;
  logic        vld;
  logic        rel_vld = 1'b0;
  logic [63:0] rel = '0;
  logic        flush = 1'b0;
  logic [63:0] fv = '0;
  logic [6:0]  cnt;
  logic        empty;
  int checks = 0;
  int errors = 0;

  bit mf [64];
  bit alloc [64];
  int ms;
  int mp;

  ct_rtu_preg_alloc_64 dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .rtu_alloc_req(req), .rtu_alloc_gnt(gnt),
    .rtu_alloc_preg_expand(expand), .rtu_alloc_vld(vld), .rtu_release_vld(rel_vld),
    .rtu_release_expand(rel), .rtu_flush(flush), .rtu_flush_free_expand(fv),
    .rtu_free_cnt(cnt), .rtu_alloc_empty(empty)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      mf[i] = 1'b1;
      alloc[i] = 1'b0;
    end
    ms = -1;
    mp = 0;
  endfunction

  function automatic void model_step();
    if (flush) begin
      for (int i = 0; i < 64; i++) begin
        mf[i] = fv[i];
        alloc[i] = !fv[i];
      end
      ms = -1;
    end else begin
      bit g = req && ms >= 0;
      if (g) alloc[ms] = 1'b1;
      if (ms < 0 || g) begin
        int n = -1;
        for (int k = 0; k < 64; k++)
          if (n < 0 && mf[(mp + k) % 64]) n = (mp + k) % 64;
        if (n >= 0) begin
          mf[n] = 1'b0;
          mp = (n + 1) % 64;
        end
        ms = n;
      end
      if (rel_vld)
        for (int i = 0; i < 64; i++)
          if (rel[i]) begin
            mf[i] = 1'b1;
            alloc[i] = 1'b0;
          end
    end
  endfunction

  function automatic logic [73:0] m_out();
    int c = (ms >= 0) ? 1 : 0;
    logic [63:0] e = (ms >= 0) ? (64'd1 << ms) : 64'd0;
    logic [6:0] c7;
    for (int i = 0; i < 64; i++) c += mf[i] ? 1 : 0;
    c7 = c[6:0];
    return {req && ms >= 0 && !flush, ms >= 0, e, c7, c == 0};
  endfunction

  function automatic logic [63:0] alloc_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < 64; i++) v[i] = alloc[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== {1'b0, 1'b0, 64'd0, 7'd64, 1'b0}) begin
      errors++;
      $display("FAIL reset_state gnt=%0b vld=%0b expand=%h cnt=%0d empty=%0b", gnt, vld, expand, cnt, empty);
    end
  endtask

  task automatic test_sequential();
    req = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      #1;
      checks++;
      if ({gnt, vld, expand, cnt, empty} !== m_out() || expand !== (64'd1 << i) || cnt !== 7'(64 - i) || gnt !== 1'b1) begin
        errors++;
        $display("FAIL seq_grant[%0d] got=%h want=%h", i, {gnt, vld, expand, cnt, empty}, m_out());
      end
      tick();
    end
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== {1'b0, 1'b0, 64'd0, 7'd0, 1'b1}) begin
      errors++;
      $display("FAIL drained gnt=%0b vld=%0b expand=%h cnt=%0d empty=%0b", gnt, vld, expand, cnt, empty);
    end
  endtask

  task automatic test_release_empty();
    rel_vld = 1'b1;
    rel = 64'd1 << 5;
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== m_out() || gnt !== 1'b0) begin
      errors++;
      $display("FAIL rel_cycle got=%h want=%h", {gnt, vld, expand, cnt, empty}, m_out());
    end
    tick();
    rel_vld = 1'b0;
    rel = '0;
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== m_out() || cnt !== 7'd1 || vld !== 1'b0) begin
      errors++;
      $display("FAIL rel_visible got=%h want=%h", {gnt, vld, expand, cnt, empty}, m_out());
    end
    tick();
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== m_out() || expand !== (64'd1 << 5) || gnt !== 1'b1 || cnt !== 7'd1) begin
      errors++;
      $display("FAIL rel_staged got=%h want=%h", {gnt, vld, expand, cnt, empty}, m_out());
    end
    tick();
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== m_out() || cnt !== 7'd0) begin
      errors++;
      $display("FAIL rel_regrant got=%h want=%h", {gnt, vld, expand, cnt, empty}, m_out());
    end
  endtask

  task automatic test_wrap();
    req = 1'b0;
    flush = 1'b1;
    fv = 64'd1 << 61;
    tick();
    flush = 1'b0;
    tick();
    flush = 1'b1;
    fv = (64'd1 << 3) | (64'd1 << 63);
    tick();
    flush = 1'b0;
    req = 1'b1;
    tick();
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== m_out() || expand !== (64'd1 << 63) || cnt !== 7'd2) begin
      errors++;
      $display("FAIL wrap_63 got=%h want=%h", {gnt, vld, expand, cnt, empty}, m_out());
    end
    tick();
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== m_out() || expand !== (64'd1 << 3)) begin
      errors++;
      $display("FAIL wrap_3 got=%h want=%h", {gnt, vld, expand, cnt, empty}, m_out());
    end
    tick();
    req = 1'b0;
    rel_vld = 1'b1;
    rel = (64'd1 << 2) | (64'd1 << 5);
    tick();
    rel_vld = 1'b0;
    rel = '0;
    tick();
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== m_out() || expand !== (64'd1 << 5)) begin
      errors++;
      $display("FAIL wrap_ptr4 got=%h want=%h", {gnt, vld, expand, cnt, empty}, m_out());
    end
  endtask

  task automatic test_flush();
    req = 1'b0;
    flush = 1'b1;
    fv = 64'd1 << 63;
    tick();
    flush = 1'b0;
    tick();
    req = 1'b1;
    flush = 1'b1;
    fv = 64'hFF00;
    rel_vld = 1'b1;
    rel = 64'd1;
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== m_out() || gnt !== 1'b0 || vld !== 1'b1) begin
      errors++;
      $display("FAIL flush_gnt got=%h want=%h", {gnt, vld, expand, cnt, empty}, m_out());
    end
    tick();
    flush = 1'b0;
    rel_vld = 1'b0;
    rel = '0;
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== m_out() || cnt !== 7'd8 || vld !== 1'b0) begin
      errors++;
      $display("FAIL flush_reload got=%h want=%h", {gnt, vld, expand, cnt, empty}, m_out());
    end
    tick();
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== m_out() || cnt !== 7'd8 || expand !== (64'd1 << 8)) begin
      errors++;
      $display("FAIL flush_resume got=%h want=%h", {gnt, vld, expand, cnt, empty}, m_out());
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      req = ($urandom % 4) != 0;
      rel_vld = ($urandom % 3) == 0;
      rel = rel_vld ? ({$urandom, $urandom} & {$urandom, $urandom} & alloc_vec()) : 64'd0;
      flush = ($urandom % 50) == 0;
      fv = {$urandom, $urandom};
      #1;
      checks++;
      if ({gnt, vld, expand, cnt, empty} !== m_out()) begin
        errors++;
        $display("FAIL random[%0d] got=%h want=%h", n, {gnt, vld, expand, cnt, empty}, m_out());
      end
      tick();
    end
    flush = 1'b0;
    rel_vld = 1'b0;
    rel = '0;
  endtask

  task automatic test_async_reset();
    req = 1'b1;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== {1'b0, 1'b0, 64'd0, 7'd64, 1'b0}) begin
      errors++;
      $display("FAIL async_reset gnt=%0b vld=%0b expand=%h cnt=%0d", gnt, vld, expand, cnt);
    end
    tick();
    tick();
    checks++;
    if ({gnt, vld, cnt} !== {1'b0, 1'b0, 7'd64}) begin
      errors++;
      $display("FAIL reset_hold gnt=%0b vld=%0b cnt=%0d", gnt, vld, cnt);
    end
    rst_n = 1'b1;
    tick();
    #1;
    checks++;
    if ({gnt, vld, expand, cnt, empty} !== m_out() || expand !== 64'd1) begin
      errors++;
      $display("FAIL reset_restart got=%h want=%h", {gnt, vld, expand, cnt, empty}, m_out());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_release_empty();
    test_wrap();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
